// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int BIT_IDX_W = 3;
  localparam int DATA_W    = 8;

  // Width of a counter that spans one serial bit period.
  function automatic int baud_cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_cmd_rx_byte_fifo.sv
// Small byte FIFO with a flop-based head; shared by the RX and future TX paths.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overrun;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = i_pop && (r_count != '0);
  assign w_push    = i_push && (!w_full || w_pop);

  assign o_data    = r_mem[r_rd_ptr];
  assign o_valid   = (r_count != '0);
  assign o_full    = w_full;
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

  // Storage, pointers (wrapping naturally at the power-of-two depth) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_push && w_full && !w_pop;
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: 2-flop synchronizer, mid-bit sampling FSM and byte FIFO.
// Optional even-parity frame (8E1) with parity_err_o when UART_RX_PARITY_EN is defined.
module uart_cmd_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          rx_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err_o
`endif
);

  localparam int BAUD_W = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  logic [BAUD_W-1:0]    r_baud_cnt;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [DATA_W-1:0]    r_shift;
  logic                 r_frame_err;
  logic                 r_stop_hold;
  logic                 w_rx_s;
  logic                 w_baud_done;
  logic                 w_stop_sample;
  logic                 w_push;
  logic                 w_full;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
`endif

  assign w_rx_s        = r_sync2;
  assign w_baud_done   = (r_baud_cnt == FULL_BIT);
  assign w_stop_sample = ena && (r_state == STOP) && !r_stop_hold && w_baud_done;
`ifdef UART_RX_PARITY_EN
  assign w_push        = w_stop_sample && w_rx_s && !r_par_bad;
  assign parity_err_o  = r_parity_err;
`else
  assign w_push        = w_stop_sample && w_rx_s;
`endif
  assign frame_err_o   = r_frame_err;

  // Two-flop synchronizer for the asynchronous serial line; idles high and ignores ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: start-bit qualification at half bit, then one sample per bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_stop_hold <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (!ena) begin
        // Disabled: drop any partial frame without flagging it.
        r_state     <= IDLE;
        r_baud_cnt  <= '0;
        r_bit_idx   <= '0;
        r_stop_hold <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_par_bad   <= 1'b0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state    <= START;
              r_baud_cnt <= '0;
            end
          end
          START: begin
            if (r_baud_cnt == HALF_BIT) begin
              r_baud_cnt <= '0;
              if (!w_rx_s) begin
                r_state   <= DATA;
                r_bit_idx <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          DATA: begin
            if (w_baud_done) begin
              r_baud_cnt <= '0;
              r_shift    <= {w_rx_s, r_shift[DATA_W-1:1]};
              if (r_bit_idx == LAST_BIT) begin
                r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                r_state   <= PARITY;
`else
                r_state   <= STOP;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_baud_done) begin
              r_baud_cnt <= '0;
              r_par_bad  <= (w_rx_s != ^r_shift);
              r_state    <= STOP;
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (r_stop_hold) begin
              // Line stuck low after a bad stop bit: wait for idle before rearming.
              if (w_rx_s) begin
                r_state     <= IDLE;
                r_stop_hold <= 1'b0;
              end
            end else if (w_baud_done) begin
              r_baud_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bad;
              r_frame_err  <= !w_rx_s || r_par_bad;
              r_par_bad    <= 1'b0;
`else
              r_frame_err  <= !w_rx_s;
`endif
              if (w_rx_s) r_state <= IDLE;
              else        r_stop_hold <= 1'b1;
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (ready_i),
    .o_data      (data_o),
    .o_valid     (valid_o),
    .o_full      (w_full),
    .o_count     (count_o),
    .o_overrun   (overrun_o)
  );

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with an expected-byte scoreboard queue.
module tb_uart_cmd_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Rising edge (counted from the start-bit drive edge) at which the stop bit
  // is sampled: 2 synchronizer edges + 1 IDLE edge + half bit + (NB-1) full bits.
  localparam int SAMPLE_C = 3 + CPB/2 + CPB*(NB-1);
  localparam int FRAME_C  = CPB*NB + 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic [2:0] count_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         model_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .count_o     (count_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [7:0] head_exp();
    return (exp_q.size() != 0) ? exp_q[0] : 8'h00;
  endfunction

  // Drives one frame starting right after a rising edge; optional abort and pop cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input int abort_c, input int pop_c);
    logic [NB-1:0] bits;
    logic          good;
    logic          exp_ovr;
    int            fe_p;
    int            ov_p;
    int            pe_p;
    good    = stop_b && !par_flip;
    exp_ovr = 1'b0;
    fe_p = 0; ov_p = 0; pe_p = 0;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[9] = (^d) ^ par_flip;
`endif
    bits[NB-1] = stop_b;
    rx_i = bits[0];
    for (int c = 1; c <= FRAME_C; c++) begin
      @(posedge clk); #1;
      if (c == abort_c) begin
        rx_i = 1'b1;
        return;
      end
      rx_i = (c < CPB*NB) ? bits[c/CPB] : 1'b1;
      if (frame_err_o) fe_p++;
      if (overrun_o) ov_p++;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) pe_p++;
`endif
      if (c == pop_c) begin
        check("pop_in_frame_data", {24'h0, data_o}, {24'h0, head_exp()});
        ready_i = 1'b1;
      end
      if (c == pop_c + 1) begin
        ready_i = 1'b0;
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          model_cnt--;
        end
      end
      if (c == SAMPLE_C - 1) begin
        check("pre_stop_count", {29'h0, count_o}, model_cnt);
        check("pre_stop_err", {31'h0, frame_err_o}, 0);
      end
      if (c == SAMPLE_C) begin
        exp_ovr = good && (model_cnt == DEPTH);
        if (good && !exp_ovr) begin
          exp_q.push_back(d);
          model_cnt++;
        end
        check("frame_err", {31'h0, frame_err_o}, {31'h0, !good});
        check("overrun", {31'h0, overrun_o}, {31'h0, exp_ovr});
        check("count", {29'h0, count_o}, model_cnt);
        check("valid", {31'h0, valid_o}, (model_cnt != 0) ? 1 : 0);
        check("head", {24'h0, data_o}, {24'h0, head_exp()});
`ifdef UART_RX_PARITY_EN
        check("parity_err", {31'h0, parity_err_o}, {31'h0, par_flip});
`endif
      end
    end
    $display("frame 0x%02h stop=%0b parflip=%0b: fe=%0d ov=%0d count=%0d",
             d, stop_b, par_flip, fe_p, ov_p, count_o);
    check("fe_pulses", fe_p, good ? 0 : 1);
    check("ov_pulses", ov_p, exp_ovr ? 1 : 0);
`ifdef UART_RX_PARITY_EN
    check("pe_pulses", pe_p, par_flip ? 1 : 0);
`endif
  endtask

  task automatic pop_one();
    logic [7:0] e;
    e = head_exp();
    check("pop_valid", {31'h0, valid_o}, 1);
    check("pop_data", {24'h0, data_o}, {24'h0, e});
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      model_cnt--;
    end
    check("pop_count", {29'h0, count_o}, model_cnt);
    $display("pop 0x%02h count=%0d", e, count_o);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int fe_p;
    int v_p;
    // Reset state
    rst_n = 1'b0; ena = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    idle(3);
    check("rst_valid", {31'h0, valid_o}, 0);
    check("rst_data", {24'h0, data_o}, 0);
    check("rst_count", {29'h0, count_o}, 0);
    check("rst_fe", {31'h0, frame_err_o}, 0);
    check("rst_ov", {31'h0, overrun_o}, 0);
    rst_n = 1'b1;
    idle(5);

    // Single byte with ready low
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    pop_one();

    // Short low glitch must not start a frame
    fe_p = 0; v_p = 0;
    rx_i = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 8) rx_i = 1'b1;
      if (frame_err_o || overrun_o) fe_p++;
      if (valid_o) v_p++;
    end
    $display("glitch: flags=%0d valid_cycles=%0d", fe_p, v_p);
    check("glitch_flags", fe_p, 0);
    check("glitch_valid", v_p, 0);

    // Bad stop bit, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    idle(4);
    send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
    pop_one();

    // Overrun on the fifth byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++) pop_one();
    check("drained", {29'h0, count_o}, 0);

    // Full FIFO with a pop on the stop-sample edge: no overrun
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, -1, -1);
    send_frame(8'h05, 1'b1, 1'b0, -1, SAMPLE_C - 1);
    for (int i = 0; i < 4; i++) pop_one();

    // ena low discards a partial frame but keeps buffered bytes
    send_frame(8'h99, 1'b1, 1'b0, -1, -1);
    send_frame(8'hC3, 1'b1, 1'b0, 80, -1);
    ena = 1'b0;
    idle(3);
    ena = 1'b1;
    idle(200);
    check("ena_count", {29'h0, count_o}, model_cnt);
    $display("ena flush: count=%0d", count_o);
    pop_one();

    // Asynchronous reset mid-byte with data buffered
    send_frame(8'h11, 1'b1, 1'b0, -1, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1, -1);
    send_frame(8'h7E, 1'b1, 1'b0, 80, -1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_cnt = 0;
    check("arst_valid", {31'h0, valid_o}, 0);
    check("arst_data", {24'h0, data_o}, 0);
    check("arst_count", {29'h0, count_o}, 0);
    check("arst_fe", {31'h0, frame_err_o}, 0);
    check("arst_ov", {31'h0, overrun_o}, 0);
    $display("async reset: valid=%0b count=%0d", valid_o, count_o);
    idle(3);
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h7E, 1'b1, 1'b0, -1, -1);
    pop_one();

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: byte dropped, both error pulses
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    check("par_drop_count", {29'h0, count_o}, 0);
    send_frame(8'h07, 1'b1, 1'b0, -1, -1);
    pop_one();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
